// File: rtl/risc_pkg.sv
// Shared definitions for the memory responder slice.
//   ADDR_W_DEF / DATA_W_DEF : default address and word widths (32 x 8-bit).
//   state_t                 : responder FSM encoding (IDLE/BUSY/RESP).
//   WAIT_CNT_W              : width of the optional wait counter (1..15 cycles).
package risc_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write port, registered read port.
// Contents are never cleared; only the read register is reset to zero.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset (read register only)
//   i_we, i_waddr,
//   i_wdata           : write strobe, address, data (committed at the edge)
//   i_re, i_raddr     : read strobe and address (sampled at the edge)
//   o_rdata           : registered read data, held until the next read
module mem_array
  import risc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write request at a time from the
// control unit, answers reads with a one-cycle rdata_valid pulse and flags
// protocol errors (rd+wr together, or any request while not ready) in a
// sticky err bit.
// Optional macro MEM_WAIT_EN: inserts WAIT_CYCLES busy cycles after every
// accepted request (reads then respond, writes return to IDLE).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rd, wr, data_e    : read strobe, write strobe, write-data enable
//   addr, data_in     : request address and write data
//   data_out          : registered read data (holds last read value)
//   rdata_valid       : one-cycle pulse, data_out valid
//   ready             : high only in IDLE
//   err               : sticky protocol-error flag
module mem_responder
  import risc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rdata_valid,
  output logic              ready,
  output logic              err
);

  // Out-of-range wait counts leave this marker block in the hierarchy.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_cycles_out_of_range
  end

  state_t r_state, w_state_nxt;
  logic   r_err;
  logic   w_idle, w_rd_acc, w_wr_acc, w_err_set;
  logic   w_re;
  logic [ADDR_W-1:0] w_raddr;

  assign w_idle    = (r_state == IDLE);
  assign w_rd_acc  = w_idle & rd & ~wr;
  // wr without data_e is a silent no-op, not an error.
  assign w_wr_acc  = w_idle & wr & ~rd & data_e;
  assign w_err_set = (w_idle & rd & wr) | (~w_idle & (rd | wr));

`ifdef MEM_WAIT_EN
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_is_rd;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_re        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_acc || w_wr_acc) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = WAIT_CNT_W'(1);
        end
      end
      BUSY: begin
        // The count includes the acceptance edge, so the final busy edge
        // is the one that performs the array read.
        if (r_cnt == WAIT_CNT_W'(WAIT_CYCLES)) begin
          w_state_nxt = r_is_rd ? RESP : IDLE;
          w_re        = r_is_rd;
        end else begin
          w_cnt_nxt = r_cnt + WAIT_CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_is_rd <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_rd_acc || w_wr_acc) begin
        r_addr  <= addr;
        r_is_rd <= w_rd_acc;
      end
    end
  end

  assign w_raddr = r_addr;
`else
  always_comb begin
    w_state_nxt = r_state;
    w_re        = w_rd_acc;
    case (r_state)
      IDLE:    if (w_rd_acc) w_state_nxt = RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The read is issued at the acceptance edge, so addr is captured there.
  assign w_raddr = addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_wr_acc),
    .i_waddr (addr),
    .i_wdata (data_in),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (data_out)
  );

  assign ready       = w_idle;
  assign rdata_valid = (r_state == RESP);
  assign err         = r_err;

endmodule
